uio_port_arbiter: RTL

Arbitrates ownership of the shared 8-bit bidirectional user IO port (uio_in/uio_out/uio_oe) between NREQ internal requesters inside the tt_um top level. It grants one requester at a time in round-robin order and drives the output enables for the granted direction. It inserts idle turnaround cycles (all pins released) on every ownership change, and bounds hold time when others are waiting.

---
 rtl/uio_port_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uio_port_arbiter.sv
// Round-robin ownership arbiter for the shared 8-bit uio pad port: one owner at a
// time, all pins released for TURN cycles between owners, hold bounded when others wait.
module uio_port_arbiter #(
   parameter int NREQ    = 4,
   parameter int TURN    = 1,
   parameter int MAXHOLD = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   dir,
   input  logic [8*NREQ-1:0] wdata,
   output logic [NREQ-1:0]   grant,
   output logic [7:0]        rdata,
   input  logic [7:0]        uio_in,
   output logic [7:0]        uio_out,
   output logic [7:0]        uio_oe,
   output logic              busy
);
   localparam int IW = $clog2(NREQ);
   localparam int TW = (TURN > 1) ? $clog2(TURN) : 1;
   localparam int HW = $clog2(MAXHOLD + 1);

   typedef enum logic [1:0] {S_IDLE, S_TURN, S_OWN} state_t;

   state_t          r_state;
   logic [IW-1:0]   r_rr;
   logic [IW-1:0]   r_win;
   logic            r_dir;
   logic [TW-1:0]   r_tcnt;
   logic [HW-1:0]   r_hold;
   logic [NREQ-1:0] r_grant;
   logic [7:0]      r_oe;
   logic [7:0]      r_rdata;

   logic [IW-1:0]   w_ptr;
   logic            w_pick_vld;
   logic [IW-1:0]   w_pick_idx;
   logic [NREQ-1:0] w_own_oh;
   logic            w_others;
   logic            w_release;

   function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NREQ) s = s - NREQ;
      return IW'(s);
   endfunction

   // While owning, the search starts after the owner so a preempted owner goes last.
   assign w_ptr = (r_state == S_OWN) ? r_win : r_rr;

   always_comb begin
      w_pick_vld = 1'b0;
      w_pick_idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         if (req[rr_idx(w_ptr, k)]) begin
            w_pick_vld = 1'b1;
            w_pick_idx = rr_idx(w_ptr, k);
         end
      end
   end

   assign w_own_oh  = NREQ'(1) << r_win;
   assign w_others  = |(req & ~w_own_oh);
   assign w_release = !req[r_win] || ((r_hold >= HW'(MAXHOLD - 1)) && w_others);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_rr    <= IW'(NREQ - 1);
         r_win   <= '0;
         r_dir   <= 1'b0;
         r_tcnt  <= '0;
         r_hold  <= '0;
         r_grant <= '0;
         r_oe    <= '0;
         r_rdata <= '0;
      end else if (!ena) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_oe    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pick_vld) begin
                  r_win   <= w_pick_idx;
                  r_dir   <= dir[w_pick_idx];
                  r_tcnt  <= TW'(TURN - 1);
                  r_state <= S_TURN;
               end
            end
            S_TURN: begin
               if (!req[r_win]) begin
                  r_state <= S_IDLE;
               end else if (r_tcnt == '0) begin
                  r_state <= S_OWN;
                  r_grant <= w_own_oh;
                  r_oe    <= {8{r_dir}};
                  r_hold  <= '0;
               end else begin
                  r_tcnt <= r_tcnt - TW'(1);
               end
            end
            S_OWN: begin
               if (!r_dir) r_rdata <= uio_in;
               if (w_release) begin
                  r_rr    <= r_win;
                  r_grant <= '0;
                  r_oe    <= '0;
                  if (w_pick_vld) begin
                     r_win   <= w_pick_idx;
                     r_dir   <= dir[w_pick_idx];
                     r_tcnt  <= TW'(TURN - 1);
                     r_state <= S_TURN;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else if (r_hold != HW'(MAXHOLD)) begin
                  r_hold <= r_hold + HW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign grant   = r_grant;
   assign uio_oe  = r_oe;
   assign rdata   = r_rdata;
   assign busy    = (r_state != S_IDLE);
   assign uio_out = (r_state == S_OWN && r_dir) ? wdata[{r_win, 3'b000} +: 8] : 8'h00;

endmodule
